// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_id_e;

    typedef struct packed {
        logic              busy;
        port_id_e          owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } stage_t;

    function automatic port_id_e gnt_to_port(input logic [1:0] gnt);
        return gnt[1] ? PORT_DBG : PORT_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's request/response channel into the data-memory arbiter.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin by default, fixed port-0 priority when
// DMEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output port_id_e   last_gnt
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign gnt      = req[0] ? 2'b01 : {req[1], 1'b0};
    assign last_gnt = PORT_DBG;
`else
    port_id_e last_q;

    // Reset value PORT_DBG makes port 0 win the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= PORT_DBG;
        end else if (advance) begin
            last_q <= gnt_to_port(gnt);
        end
    end

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = (last_q == PORT_CPU) ? 2'b10 : 2'b01;
        end
    end

    assign last_gnt = last_q;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto the single-port data memory through one
// registered access stage; responses return two cycles after grant.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed port-0 priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     port0,
    dmem_arbiter_if.slave     port1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    port_id_e          arb_last_unused;
    stage_t            stage_d;
    stage_t            stage_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q;
    logic [DATA_W-1:0] rsp1_rdata_q;

    assign req    = {port1.req_valid, port0.req_valid};
    assign accept = |gnt;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .advance  (accept),
        .gnt      (gnt),
        .last_gnt (arb_last_unused)
    );

    // Ready is gated by reset so nothing looks accepted while held in reset.
    assign port0.req_ready = gnt[0] & reset;
    assign port1.req_ready = gnt[1] & reset;

    always_comb begin
        stage_d = '0;
        if (gnt[1]) begin
            stage_d.busy  = 1'b1;
            stage_d.owner = PORT_DBG;
            stage_d.we    = port1.req_we;
            stage_d.addr  = port1.req_addr;
            stage_d.wdata = port1.req_wdata;
        end else if (gnt[0]) begin
            stage_d.busy  = 1'b1;
            stage_d.owner = PORT_CPU;
            stage_d.we    = port0.req_we;
            stage_d.addr  = port0.req_addr;
            stage_d.wdata = port0.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Memory strobes come straight from the stage so an async reset kills
    // an in-flight write before the next edge.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        if (stage_q.busy) begin
            mem_addr  = stage_q.addr;
            mem_wdata = stage_q.wdata;
            mem_wr_en = stage_q.we;
            mem_rd_en = !stage_q.we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_valid_q <= stage_q.busy && (stage_q.owner == PORT_CPU);
            rsp1_valid_q <= stage_q.busy && (stage_q.owner == PORT_DBG);
            if (stage_q.busy && (stage_q.owner == PORT_CPU)) begin
                rsp0_rdata_q <= stage_q.we ? '0 : mem_rdata;
            end
            if (stage_q.busy && (stage_q.owner == PORT_DBG)) begin
                rsp1_rdata_q <= stage_q.we ? '0 : mem_rdata;
            end
        end
    end

    assign port0.rsp_valid = rsp0_valid_q;
    assign port0.rsp_rdata = rsp0_rdata_q;
    assign port1.rsp_valid = rsp1_valid_q;
    assign port1.rsp_rdata = rsp1_rdata_q;

endmodule
